// File: rtl/sp_sram_be_init_if.sv
// Bus bundle for the single-port SRAM with byte strobes and a clear engine.
// An access is accepted on a rising edge where en=1 and ready=1; while ready=0 the slave ignores en.
interface sp_sram_be_init_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 10
);
  logic                      en;
  logic                      we;
  logic [DATA_WIDTH/8-1:0]   be;
  logic [ADDR_BITS-1:0]      addr;
  logic [DATA_WIDTH-1:0]     din;
  logic [DATA_WIDTH-1:0]     dout;
  logic                      rvalid;
  logic                      init_req;
  logic                      ready;
  logic                      init_done;

  modport master (
    output en, we, be, addr, din, init_req,
    input  dout, rvalid, ready, init_done
  );

  modport slave (
    input  en, we, be, addr, din, init_req,
    output dout, rvalid, ready, init_done
  );
endinterface

// File: rtl/sp_sram_be_init.sv
// Single-port synchronous SRAM with byte write strobes, 1- or 2-cycle read latency,
// a read-valid strobe and a clear engine that fills the array with INIT_VALUE.
module sp_sram_be_init #(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    ADDR_BITS     = 10,
  parameter int                    MEM_DEPTH     = 1024,
  parameter int                    READ_LATENCY  = 1,
  parameter int                    INIT_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  sp_sram_be_init_if.slave        bus,
  output logic [1:0]              state_dbg
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_BITS:0] DEPTH_W = (ADDR_BITS+1)'(MEM_DEPTH);
  localparam logic [IDX_W-1:0]   LAST    = IDX_W'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   cnt, cnt_nxt;
  logic               init_wr;
  logic               ready_i;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  acc;
  logic                  in_range;
  logic [IDX_W-1:0]      idx;
  logic                  acc_wr;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] stg_data;
  logic                  stg_valid;

  // ---------------------------------------------------------------------------
  // Clear-engine FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= (INIT_ON_RESET != 0) ? S_INIT : S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    init_wr   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.init_req) begin
          state_nxt = S_INIT;
          cnt_nxt   = '0;
        end
      end
      S_INIT: begin
        init_wr = 1'b1;
        if (cnt == LAST) begin
          state_nxt = S_DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + IDX_W'(1);
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign ready_i       = (state == S_IDLE);
  assign bus.ready     = ready_i;
  assign bus.init_done = (state == S_DONE);
  assign state_dbg     = state;

  // ---------------------------------------------------------------------------
  // Access decode and storage
  // ---------------------------------------------------------------------------
  assign acc      = bus.en & ready_i;
  assign in_range = ({1'b0, bus.addr} < DEPTH_W);
  assign idx      = bus.addr[IDX_W-1:0];
  assign acc_wr   = acc & bus.we & in_range;
  assign rd_acc   = acc & ~bus.we;
  assign rd_word  = in_range ? mem[idx] : '0;

  // The clear engine owns the port whenever it runs; ready=0 keeps accesses out.
  always_ff @(posedge clk) begin
    if (init_wr) begin
      mem[cnt] <= INIT_VALUE;
    end else if (acc_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.be[i]) mem[idx][8*i +: 8] <= bus.din[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline
  // ---------------------------------------------------------------------------
  generate
    if (READ_LATENCY == 2) begin : g_lat2
      // Extra stage keeps draining while a clear runs, so a read accepted just
      // before the clear still completes.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stg_valid <= 1'b0;
          stg_data  <= '0;
        end else begin
          stg_valid <= rd_acc;
          if (rd_acc) stg_data <= rd_word;
        end
      end
    end else begin : g_lat1
      assign stg_valid = rd_acc;
      assign stg_data  = rd_word;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rvalid <= 1'b0;
      bus.dout   <= '0;
    end else begin
      bus.rvalid <= stg_valid;
      if (stg_valid) bus.dout <= stg_data;
    end
  end

endmodule

// File: tb/tb_sp_sram_be_init.sv
// Directed bench driving a latency-1 and a latency-2 instance with identical stimulus;
// read results are checked against a byte-accurate memory model through expected queues.
module tb_sp_sram_be_init;

  localparam int DW    = 32;
  localparam int AB    = 4;
  localparam int DEPTH = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sp_sram_be_init_if #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) b1 ();
  sp_sram_be_init_if #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) b2 ();
  logic [1:0] st1, st2;

  assign b2.en       = b1.en;
  assign b2.we       = b1.we;
  assign b2.be       = b1.be;
  assign b2.addr     = b1.addr;
  assign b2.din      = b1.din;
  assign b2.init_req = b1.init_req;

  sp_sram_be_init #(
    .DATA_WIDTH(DW), .ADDR_BITS(AB), .MEM_DEPTH(DEPTH),
    .READ_LATENCY(1), .INIT_ON_RESET(1), .INIT_VALUE('0)
  ) dut1 (.clk(clk), .rst(rst), .bus(b1), .state_dbg(st1));

  sp_sram_be_init #(
    .DATA_WIDTH(DW), .ADDR_BITS(AB), .MEM_DEPTH(DEPTH),
    .READ_LATENCY(2), .INIT_ON_RESET(1), .INIT_VALUE('0)
  ) dut2 (.clk(clk), .rst(rst), .bus(b2), .state_dbg(st2));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_q1[$];
  logic [DW-1:0] exp_q2[$];
  logic mon_en = 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst && b1.rvalid) begin
      if (exp_q1.size() == 0) check("l1_spurious_rvalid", DW'(b1.rvalid), '0);
      else check("l1_dout", b1.dout, exp_q1.pop_front());
    end
  end

  always @(negedge clk) begin
    if (mon_en && !rst && b2.rvalid) begin
      if (exp_q2.size() == 0) check("l2_spurious_rvalid", DW'(b2.rvalid), '0);
      else check("l2_dout", b2.dout, exp_q2.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    b1.en       = 1'b0;
    b1.we       = 1'b0;
    b1.init_req = 1'b0;
  endtask

  task automatic wr(input logic [AB-1:0] a, input logic [DW-1:0] d,
                    input logic [3:0] be, input logic req);
    b1.en = 1'b1; b1.we = 1'b1; b1.addr = a; b1.din = d; b1.be = be; b1.init_req = req;
    if (int'(a) < DEPTH) begin
      for (int i = 0; i < 4; i++) if (be[i]) model[a][8*i +: 8] = d[8*i +: 8];
    end
    tick();
    drive_idle();
  endtask

  task automatic rd(input logic [AB-1:0] a, input logic req);
    logic [DW-1:0] e;
    e = (int'(a) < DEPTH) ? model[a] : '0;
    b1.en = 1'b1; b1.we = 1'b0; b1.addr = a; b1.be = $urandom_range(0, 15); b1.init_req = req;
    exp_q1.push_back(e);
    exp_q2.push_back(e);
    tick();
    drive_idle();
  endtask

  task automatic check_ready(input string tag, input logic exp_ready, input logic exp_done);
    check({tag, "_ready1"}, DW'(b1.ready), DW'(exp_ready));
    check({tag, "_ready2"}, DW'(b2.ready), DW'(exp_ready));
    check({tag, "_done1"},  DW'(b1.init_done), DW'(exp_done));
    check({tag, "_done2"},  DW'(b2.init_done), DW'(exp_done));
  endtask

  // Call right after the clear has been entered (counter at 0).
  task automatic run_clear(input string tag, input logic hammer);
    for (int i = 0; i < DEPTH; i++) begin
      check_ready(tag, 1'b0, 1'b0);
      if (hammer) begin
        b1.en   = 1'b1;
        b1.we   = i[0];
        b1.addr = AB'(DEPTH - 1 - i);
        b1.din  = 32'hFFFF_FFFF;
        b1.be   = 4'hF;
      end
      tick();
    end
    drive_idle();
    check_ready({tag, "_donecyc"}, 1'b0, 1'b1);
    tick();
    check_ready({tag, "_idle"}, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic drain(input string tag);
    repeat (4) tick();
    check({tag, "_q1_empty"}, DW'(exp_q1.size()), '0);
    check({tag, "_q2_empty"}, DW'(exp_q2.size()), '0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    drive_idle();
    b1.addr = '0; b1.din = '0; b1.be = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    // Reset values
    rst = 1'b1;
    repeat (3) tick();
    check("rst_dout1", b1.dout, '0);
    check("rst_dout2", b2.dout, '0);
    check("rst_rvalid1", DW'(b1.rvalid), '0);
    check("rst_rvalid2", DW'(b2.rvalid), '0);
    check_ready("rst", 1'b0, 1'b0);

    // Power-on clear, then read every location
    rst = 1'b0;
    mon_en = 1'b1;
    run_clear("por", 1'b0);
    for (int a = 0; a < DEPTH; a++) rd(AB'(a), 1'b0);
    drain("por_rd");

    // Byte strobes and latency
    wr(4'd5, 32'hAABB_CCDD, 4'b1111, 1'b0);
    wr(4'd5, 32'h1122_3344, 4'b0101, 1'b0);
    check("be_model", model[5], 32'hAA22_CC44);
    rd(4'd5, 1'b0);
    check("lat_rvalid1_c1", DW'(b1.rvalid), DW'(1));
    check("lat_rvalid2_c1", DW'(b2.rvalid), '0);
    tick();
    check("lat_rvalid1_c2", DW'(b1.rvalid), '0);
    check("lat_rvalid2_c2", DW'(b2.rvalid), DW'(1));
    tick();
    check("hold_dout1", b1.dout, 32'hAA22_CC44);
    check("hold_dout2", b2.dout, 32'hAA22_CC44);
    check("hold_rvalid2", DW'(b2.rvalid), '0);
    wr(4'd5, 32'hFFFF_FFFF, 4'b0000, 1'b0);
    rd(4'd5, 1'b0);
    drain("be");

    // Back-to-back reads
    for (int a = 0; a < 4; a++) wr(AB'(a), DW'(32'h10 + a), 4'hF, 1'b0);
    for (int a = 0; a < 4; a++) rd(AB'(a), 1'b0);
    drain("b2b");

    // Clear requested together with a write; accesses during the clear are ignored
    wr(4'd2, 32'h0000_DEAD, 4'hF, 1'b1);
    run_clear("clr_wr", 1'b1);
    for (int a = 0; a < DEPTH; a++) rd(AB'(a), 1'b0);
    drain("clr_wr");

    // Read accepted in the same cycle as the clear request still completes
    wr(4'd7, 32'h0000_0077, 4'hF, 1'b0);
    rd(4'd7, 1'b1);
    run_clear("clr_rd", 1'b0);
    drain("clr_rd");

    // Reset in the middle of a clear
    wr(4'd0, 32'hCAFE_F00D, 4'hF, 1'b0);
    wr(4'd11, 32'h1234_5678, 4'hF, 1'b0);
    rd(4'd11, 1'b0);
    drain("pre_rst");
    b1.init_req = 1'b1;
    tick();
    drive_idle();
    repeat (7) tick();
    rst = 1'b1;
    tick();
    check("midrst_dout1", b1.dout, '0);
    check("midrst_rvalid1", DW'(b1.rvalid), '0);
    check("midrst_rvalid2", DW'(b2.rvalid), '0);
    tick();
    rst = 1'b0;
    run_clear("rst_mid", 1'b0);
    for (int a = 0; a < DEPTH; a++) rd(AB'(a), 1'b0);
    drain("rst_mid");

    // Out-of-range accesses
    for (int a = 0; a < DEPTH; a++) wr(AB'(a), DW'(32'hA0 + a), 4'hF, 1'b0);
    wr(4'd14, 32'h0000_0055, 4'hF, 1'b0);
    rd(4'd14, 1'b0);
    for (int a = 0; a < DEPTH; a++) rd(AB'(a), 1'b0);
    drain("oor");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sp_sram_be_init.md
Name: sp_sram_be_init

Overview:
- Parametrised single-port synchronous SRAM. Successor to the basic single-port RAM.
- Adds per-byte write strobes and a selectable read latency of 1 or 2 cycles.
- Adds a read-data valid strobe and a hardware clear engine that fills the array with a constant after reset or on request.
- Sits behind the APB slave as the storage bank; the slave must hold off accesses while ready is low.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_BITS, 10, address width.
- MEM_DEPTH, 1024, number of words; must be <= 2^ADDR_BITS.
- READ_LATENCY, 1, cycles from read request to dout/rvalid; legal values are 1 or 2.
- INIT_ON_RESET, 1, 1 = clear engine runs automatically after reset; 0 = block is ready immediately.
- INIT_VALUE, 0, DATA_WIDTH-bit word written to every location by the clear engine.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  access request; sampled only when ready=1.
- we  input  1  1 = write, 0 = read; qualified by en.
- be  input  DATA_WIDTH/8  byte write strobes; be[i] covers din[8i+7:8i].
- addr  input  ADDR_BITS  word address.
- din  input  DATA_WIDTH  write data.
- dout  output  DATA_WIDTH  read data (registered).
- rvalid  output  1  one-cycle pulse marking dout valid for a read.
- init_req  input  1  request a clear of the whole array.
- ready  output  1  1 = accepting accesses (IDLE state).
- init_done  output  1  one-cycle pulse at completion of a clear.

Behaviour:
- Reset (async, rst=1):
  - dout=0, rvalid=0, init_done=0, all read-pipeline registers=0, clear counter=0.
  - State goes to INIT if INIT_ON_RESET=1, else IDLE.
  - ready follows state: 0 in INIT, 1 in IDLE.
  - Memory contents are not reset.
- FSM states: IDLE, INIT, DONE.
  - IDLE: ready=1. init_req=1 goes to INIT next cycle with counter=0.
  - INIT: ready=0. Each cycle, mem[counter] <= INIT_VALUE and counter increments. At counter==MEM_DEPTH-1, that write happens and state goes to DONE. INIT lasts exactly MEM_DEPTH cycles.
  - DONE: ready=0, init_done=1 for this single cycle. Next state is IDLE.
  - init_req is ignored in INIT and DONE.
- Access acceptance: the access is accepted when en=1 and ready=1 at the clock edge.
  - When ready=0, en is ignored: no write, no rvalid, dout unchanged.
  - An access presented in the same cycle as init_req in IDLE is still accepted and performed. The clear starts on the following cycle.
- Write (accepted, we=1):
  - For each i with be[i]=1, byte i of mem[addr] <= din byte i. Other bytes are unchanged.
  - be all zero = no change.
  - dout and rvalid are unaffected.
- Read (accepted, we=0):
  - READ_LATENCY=1: dout <= mem[addr] and rvalid=1 on the next edge.
  - READ_LATENCY=2: data is staged in an internal register. dout and rvalid appear one edge later.
  - Back-to-back reads every cycle give one rvalid per read, in order, at full throughput.
  - be is ignored on reads.
- dout holds its last read value until the next read completes; rvalid=0 between reads.
- A read that completes during a clear (READ_LATENCY=2, read accepted just before init_req took effect) still delivers its data and rvalid.
- Out-of-range address (addr >= MEM_DEPTH): writes are dropped; reads return 0 with rvalid.
- Access to an address written on the previous cycle returns the new data. No same-cycle hazard exists with a single port.
- Reset asserted mid-INIT: counter returns to 0. With INIT_ON_RESET=1 the clear restarts from location 0 after reset is released. Pending read pipeline contents are discarded (rvalid=0).

Test Plan:
- INIT_ON_RESET=1, MEM_DEPTH=16: release rst -> ready=0 for 16 cycles, then init_done pulses for 1 cycle, then ready=1. Read all 16 addresses -> each returns INIT_VALUE (0).
- Write addr=5, din=0xAABBCCDD, be=4'b1111; then write addr=5, din=0x11223344, be=4'b0101; read addr=5 -> dout=0xAA22CC44. rvalid is 1 cycle after the read with READ_LATENCY=1, 2 cycles after with READ_LATENCY=2.
- Write addresses 0..3 with values 0x10..0x13, then issue back-to-back reads of 0..3 -> four consecutive rvalid pulses with dout 0x10, 0x11, 0x12, 0x13 in order.
- In IDLE, assert init_req together with a write of 0xDEAD to addr=2. Then assert en with reads during the clear -> ready=0 for MEM_DEPTH cycles, reads produce no rvalid. After init_done, read addr=2 -> 0 (the clear overwrote 0xDEAD).
- Assert rst at cycle 7 of a clear, hold it 2 cycles, release -> counter restarts at 0. init_done occurs MEM_DEPTH+1 cycles after release; ready rises with IDLE.
- MEM_DEPTH=12, ADDR_BITS=4: write 0x55 to addr=14, then read addr=14 -> dout=0 with rvalid. Memory locations 0..11 are unchanged.
